// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one single-port data memory between two requesters, the core port
//   (c_*) and the debug port (d_*). One request is served at a time in three
//   phases: accept (IDLE), memory strobe (ACCESS) and completion pulse (RESP).
//   When both ports request together, the port that was not granted last
//   wins (round-robin). After reset the core wins the first tie.
//
// Ports:
//   clk                          single clock, rising edge
//   reset                        asynchronous, active-low reset
//   c_valid / d_valid            request valid
//   c_we / d_we                  request is a write (1) or a read (0)
//   c_addr / d_addr              request word address
//   c_wdata / d_wdata            request write data
//   c_ready / d_ready            request accepted this cycle
//   c_rsp_valid / d_rsp_valid    one-cycle completion pulse
//   c_rsp_rdata / d_rsp_rdata    read data, valid with rsp_valid (0 on writes)
//   mem_en / mem_we              memory access strobe / write enable
//   mem_addr / mem_wdata         memory address / write data (0 when idle)
//   mem_rdata                    memory read data, valid the cycle after a read
//   busy                         high whenever an access is in progress
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              c_valid,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ready,
    output logic              c_rsp_valid,
    output logic [DATA_W-1:0] c_rsp_rdata,

    input  logic              d_valid,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_lastDebug;
    logic                r_ownerDebug;
    logic                r_we;
    logic                r_busy;
    logic                r_memEn;
    logic                r_memWe;
    logic [ADDR_W-1:0]   r_memAddr;
    logic [DATA_W-1:0]   r_memWdata;
    logic                r_cRspValid;
    logic                r_dRspValid;

    logic                w_idle;
    logic                w_grantCore;
    logic                w_grantDebug;
    logic                w_accept;
    logic                w_selWe;
    logic [ADDR_W-1:0]   w_selAddr;
    logic [DATA_W-1:0]   w_selWdata;

    // Grant decision. Ready is combinational so a requester sees acceptance
    // in the same cycle it presents valid. A lone requester always wins; on a
    // tie the pointer picks the port that was not granted last. Gating with
    // reset keeps both readies low while reset is held, even though the
    // state register already sits in IDLE.
    assign w_idle       = reset && (r_state == IDLE);
    assign w_grantCore  = w_idle && c_valid && (!d_valid || r_lastDebug);
    assign w_grantDebug = w_idle && d_valid && (!c_valid || !r_lastDebug);
    assign w_accept     = w_grantCore || w_grantDebug;

    assign c_ready = w_grantCore;
    assign d_ready = w_grantDebug;

    // The winner's request fields, captured at the accepting edge.
    assign w_selWe    = w_grantDebug ? d_we    : c_we;
    assign w_selAddr  = w_grantDebug ? d_addr  : c_addr;
    assign w_selWdata = w_grantDebug ? d_wdata : c_wdata;

    // Main controller. The memory strobe and completion pulses are held in
    // registers that are loaded one edge ahead of the phase they belong to,
    // so every output except ready and rsp_rdata comes straight from a flop.
    // The memory address/data registers double as the request latch: they
    // are loaded at accept, drive the memory for the single ACCESS cycle and
    // are cleared afterwards so the bus reads 0 while idle. An asynchronous
    // reset drops everything at once, which also abandons an access in
    // flight without ever producing its response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_lastDebug  <= 1'b1;
            r_ownerDebug <= 1'b0;
            r_we         <= 1'b0;
            r_busy       <= 1'b0;
            r_memEn      <= 1'b0;
            r_memWe      <= 1'b0;
            r_memAddr    <= '0;
            r_memWdata   <= '0;
            r_cRspValid  <= 1'b0;
            r_dRspValid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state      <= ACCESS;
                        r_busy       <= 1'b1;
                        r_ownerDebug <= w_grantDebug;
                        r_lastDebug  <= w_grantDebug;
                        r_we         <= w_selWe;
                        r_memEn      <= 1'b1;
                        r_memWe      <= w_selWe;
                        r_memAddr    <= w_selAddr;
                        r_memWdata   <= w_selWdata;
                    end
                end

                ACCESS: begin
                    r_state     <= RESP;
                    r_memEn     <= 1'b0;
                    r_memWe     <= 1'b0;
                    r_memAddr   <= '0;
                    r_memWdata  <= '0;
                    r_cRspValid <= !r_ownerDebug;
                    r_dRspValid <= r_ownerDebug;
                end

                RESP: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_cRspValid <= 1'b0;
                    r_dRspValid <= 1'b0;
                end

                default: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_memEn     <= 1'b0;
                    r_memWe     <= 1'b0;
                    r_memAddr   <= '0;
                    r_memWdata  <= '0;
                    r_cRspValid <= 1'b0;
                    r_dRspValid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_en    = r_memEn;
    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign busy      = r_busy;

    assign c_rsp_valid = r_cRspValid;
    assign d_rsp_valid = r_dRspValid;

    // Memory read data only arrives during the response cycle, so it is
    // passed through combinationally and gated to the owning port; writes
    // and the non-owner always see 0.
    assign c_rsp_rdata = (r_cRspValid && !r_we) ? mem_rdata : '0;
    assign d_rsp_rdata = (r_dRspValid && !r_we) ? mem_rdata : '0;

endmodule
